shiftrow: RTL and testbench
===========================

# shiftrow

Registered AES-128 ShiftRows stage for the AES-128 datapath. It takes one 128-bit state per clock and cyclically rotates rows 1–3 of the 4x4 byte matrix. The result is registered, so it appears one cycle later. The block sits between SubBytes and MixColumns in the encryption round. With `INVERSE=1` it is the InvShiftRows stage of the decryption round.

## Interface
Parameters:
- `INVERSE`, default 0. Selects the rotation direction: 0 = forward ShiftRows (rotate left); 1 = InvShiftRows (rotate right).

Ports:
- `CLK`  in  1  Single clock; all state updates on the rising edge.
- `RST`  in  1  Reset, synchronous and active-high.
- `Valid_in`  in  1  Qualifies `Data_in`. Only sideband; data is registered every cycle regardless.
- `Data_in`  in  128  Input AES state.
- `Valid_out`  out  1  `Valid_in` delayed one cycle.
- `Data_out`  out  128  Shifted AES state, registered.

## Operation
Byte and matrix mapping:
- Byte k occupies bits [8k+7:8k], for k = 0..15.
- Byte k is matrix element s(r,c), with r = k mod 4 and c = k div 4 (column-major order).
- Byte 0 (LSB) is therefore s(0,0), and byte 15 (MSB) is s(3,3).

Forward transform (`INVERSE=0`):
- out(r,c) = in(r,(c+r) mod 4).
- Row 0 is unchanged; row 1 rotates left by 1 byte, row 2 by 2, row 3 by 3.
- Output byte k, for k = 0..15, is taken from input byte 0,5,10,15, 4,9,14,3, 8,13,2,7, 12,1,6,11.

Inverse transform (`INVERSE=1`):
- out(r,c) = in(r,(c−r) mod 4).
- Output byte k, for k = 0..15, is taken from input byte 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3.

General rules:
- Pure byte permutation: no arithmetic, no byte content altered, no combinational path from `Data_in` to `Data_out`.
- The permutation is fixed wiring, with no runtime select.
- `Valid_in` never gates the data register. A bubble still passes its data through, flagged with `Valid_out`=0.

## Timing
- Latency is exactly 1 cycle; throughput is one state per cycle, and there is no back-pressure.
- At rising edge n, `Data_out` ← P(`Data_in` sampled at edge n), where P is the permutation, and `Valid_out` ← `Valid_in`.
- Reset is synchronous: with `RST`=1 at an edge, `Data_out` ← 128'h0 and `Valid_out` ← 0. Reset overrides any concurrent valid input.
- Reset is ignored between edges.
- First edge after `RST` falls: normal capture resumes on that same edge.
- `RST` asserted mid-stream: the state that edge would have captured is lost; the next state accepted is the one present at the first edge with `RST`=0.
- Before the first reset, outputs are X in simulation. An unknown or X `Valid_in` propagates only to `Valid_out`.

## Test plan
- Reset: hold `RST`=1 for 2 edges with `Data_in`=all-ones and `Valid_in`=1 → `Data_out`=128'h0 and `Valid_out`=0 after each edge.
- Row-0 invariance (`INVERSE=0`): `Data_in`=128'h01 → after 1 edge `Data_out`=128'h01 (byte 0 stays put).
- Row-3 rotation (`INVERSE=0`): `Data_in`=128'h11000000_00000000_00000000_00000000 (byte 15) → `Data_out`=128'h00000000_00000000_00000000_11000000 (byte 3).
- Full permutation (`INVERSE=0`): `Data_in`=128'h0f0e0d0c_0b0a0908_07060504_03020100 → `Data_out`=128'h0b06010c_07020d08_030e0904_0f0a0500.
- Inverse round trip: feed the forward result above into an `INVERSE=1` instance → `Data_out`=128'h0f0e0d0c_0b0a0908_07060504_03020100. Also feed 200 random states through forward then inverse → identity, and check popcount is preserved in each stage.
- Streaming and valid: apply a new state every cycle with the `Valid_in` pattern 1,0,1,1 → each `Data_out` is the permutation of the previous cycle's input, and `Valid_out` equals the pattern delayed by 1. Pulse `RST` for one edge mid-stream → that edge yields 0/0, and the next edge resumes correctly.

Source files
------------

// File: rtl/shiftrow.sv
// shiftrow: registered AES-128 ShiftRows / InvShiftRows stage.
// The 128-bit state is a column-major 4x4 byte matrix: byte k sits at
// bits [8k+7:8k] and is element s(r,c) with r = k mod 4, c = k div 4.
// Forward mode rotates row r left by r bytes; inverse mode rotates right.
// The byte permutation is pure wiring resolved at elaboration time.
module shiftrow #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         Valid_in,
  input  logic [127:0] Data_in,
  output logic         Valid_out,
  output logic [127:0] Data_out
);

  logic [127:0] perm_s;
  logic [127:0] data_d;
  logic [127:0] data_q;
  logic         valid_d;
  logic         valid_q;

  // Fixed byte routing: output byte k takes input byte s(r, (c +/- r) mod 4).
  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int unsigned ROW     = k % 4;
    localparam int unsigned COL     = k / 4;
    localparam int unsigned SRC_COL = INVERSE ? ((COL + 4 - ROW) % 4)
                                              : ((COL + ROW) % 4);
    localparam int unsigned SRC     = SRC_COL * 4 + ROW;
    assign perm_s[8*k +: 8] = Data_in[8*SRC +: 8];
  end

  // Next-state: data is captured every cycle; valid is a pure sideband.
  always_comb begin
    data_d  = perm_s;
    valid_d = Valid_in;
  end

  // Output registers with synchronous reset that overrides any valid input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q  <= 128'h0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Data_out  = data_q;
  assign Valid_out = valid_q;

endmodule

// File: tb/tb_shiftrow.sv
// tb_shiftrow: forward and inverse shiftrow instances chained back to back,
// checked every cycle against a byte-table reference model.
module tb_shiftrow;

  logic         clk;
  logic         rst;
  logic         vin;
  logic [127:0] din;
  logic         fwd_vout;
  logic [127:0] fwd_dout;
  logic         inv_vout;
  logic [127:0] inv_dout;

  int checks   = 0;
  int failures = 0;

  // Source byte index for each output byte, straight from the AES definition.
  int unsigned fwd_tab [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};
  int unsigned inv_tab [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  // Reference model state: what each stage should hold after the last edge.
  logic [127:0] exp_fwd_d;
  logic         exp_fwd_v;
  logic [127:0] exp_inv_d;
  logic         exp_inv_v;
  logic [127:0] prev_d;
  logic         prev_r;

  shiftrow #(.INVERSE(1'b0)) u_fwd (
    .CLK       (clk),
    .RST       (rst),
    .Valid_in  (vin),
    .Data_in   (din),
    .Valid_out (fwd_vout),
    .Data_out  (fwd_dout)
  );

  shiftrow #(.INVERSE(1'b1)) u_inv (
    .CLK       (clk),
    .RST       (rst),
    .Valid_in  (fwd_vout),
    .Data_in   (fwd_dout),
    .Valid_out (inv_vout),
    .Data_out  (inv_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] permute(input logic [127:0] x, input bit inverse);
    logic [127:0] y;
    y = 128'h0;
    for (int k = 0; k < 16; k++) begin
      if (inverse) y[8*k +: 8] = x[8*inv_tab[k] +: 8];
      else         y[8*k +: 8] = x[8*fwd_tab[k] +: 8];
    end
    return y;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock edge: apply inputs, advance the model, compare both stages.
  task automatic step(input logic r, input logic v, input logic [127:0] d);
    logic [127:0] nxt_inv_d;
    logic         nxt_inv_v;
    rst = r;
    vin = v;
    din = d;
    @(posedge clk);
    #1;
    nxt_inv_d = r ? 128'h0 : permute(exp_fwd_d, 1'b1);
    nxt_inv_v = r ? 1'b0   : exp_fwd_v;
    exp_fwd_d = r ? 128'h0 : permute(d, 1'b0);
    exp_fwd_v = r ? 1'b0   : v;
    exp_inv_d = nxt_inv_d;
    exp_inv_v = nxt_inv_v;
    check_val("fwd_data",  fwd_dout, exp_fwd_d);
    check_val("fwd_valid", {127'h0, fwd_vout}, {127'h0, exp_fwd_v});
    check_val("inv_data",  inv_dout, exp_inv_d);
    check_val("inv_valid", {127'h0, inv_vout}, {127'h0, exp_inv_v});
    if (!r) begin
      check_val("fwd_popcount", 128'($countones(fwd_dout)), 128'($countones(d)));
    end
    if (!r && !prev_r) begin
      check_val("round_trip", inv_dout, prev_d);
      check_val("inv_popcount", 128'($countones(inv_dout)), 128'($countones(prev_d)));
    end
    prev_r = r;
    prev_d = d;
  endtask

  initial begin
    logic [3:0] vpat;
    rst    = 1'b1;
    vin    = 1'b1;
    din    = '1;
    prev_r = 1'b1;
    prev_d = 128'h0;
    exp_fwd_d = 128'h0;
    exp_fwd_v = 1'b0;
    exp_inv_d = 128'h0;
    exp_inv_v = 1'b0;

    // Reset held for two edges with all-ones data and valid high.
    step(1'b1, 1'b1, '1);
    check_val("reset_data_0", fwd_dout, 128'h0);
    step(1'b1, 1'b1, '1);
    check_val("reset_data_1", fwd_dout, 128'h0);
    check_val("reset_valid", {127'h0, fwd_vout}, 128'h0);

    // Directed forward patterns.
    step(1'b0, 1'b1, 128'h01);
    check_val("row0_fixed", fwd_dout, 128'h01);
    step(1'b0, 1'b1, 128'h11000000_00000000_00000000_00000000);
    check_val("row3_rotate", fwd_dout, 128'h00000000_00000000_00000000_11000000);
    step(1'b0, 1'b1, 128'h0f0e0d0c_0b0a0908_07060504_03020100);
    check_val("full_perm", fwd_dout, 128'h0b06010c_07020d08_030e0904_0f0a0500);
    step(1'b0, 1'b0, rand128());
    check_val("inverse_full", inv_dout, 128'h0f0e0d0c_0b0a0908_07060504_03020100);

    // Streaming with valid pattern 1,0,1,1 and a mid-stream reset pulse.
    vpat = 4'b1101;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, vpat[i % 4], rand128());
    end
    step(1'b1, 1'b1, rand128());
    check_val("midreset_data", fwd_dout, 128'h0);
    check_val("midreset_valid", {127'h0, fwd_vout}, 128'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, vpat[i], rand128());
    end

    // Random states through forward then inverse.
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), rand128());
    end
    step(1'b0, 1'b0, 128'h0);
    step(1'b0, 1'b0, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
